// File: rtl/rptr_empty_lvl.sv
// rptr_empty_lvl: read-side pointer, empty/almost-empty/level and sticky underflow status for a dual-clock FIFO
module rptr_empty_lvl #(
  parameter int ASIZE = 4,
  parameter int AEMPTY_LVL = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rinc,
  input  logic [ASIZE:0]   rq2_wptr,
  input  logic             rclr_err,
  output logic [ASIZE-1:0] raddr,
  output logic [ASIZE:0]   rptr,
  output logic             rempty,
  output logic             raempty,
  output logic [ASIZE:0]   rlevel,
  output logic             runderflow
);
  localparam logic [ASIZE:0] AE = (ASIZE+1)'(AEMPTY_LVL);
  logic [ASIZE:0] rbin, rbin_next, rgray_next, wbin, lvl_next;
  assign raddr = rbin[ASIZE-1:0];
  // next pointers; write pointer decoded from Gray as a prefix XOR from the MSB down
  always_comb begin
    rbin_next = rbin + (ASIZE+1)'(rinc & ~rempty);
    rgray_next = (rbin_next >> 1) ^ rbin_next;
    for (int i = 0; i <= ASIZE; i++) wbin[i] = ^(rq2_wptr >> i);
    lvl_next = wbin - rbin_next;
  end
  // pointer and status registers describe the state after the edge
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin <= '0;
      rptr <= '0;
      rempty <= 1'b1;
      raempty <= 1'b1;
      rlevel <= '0;
      runderflow <= 1'b0;
    end else begin
      rbin <= rbin_next;
      rptr <= rgray_next;
      rempty <= rgray_next == rq2_wptr;
      raempty <= lvl_next <= AE;
      rlevel <= lvl_next;
      runderflow <= (rinc & rempty) | (runderflow & ~rclr_err);
    end
  end
endmodule

// File: tb/tb_rptr_empty_lvl.sv
// tb_rptr_empty_lvl: directed self-checking bench for rptr_empty_lvl
module tb_rptr_empty_lvl;
  logic clk = 0, rrst = 1, rinc = 0, rclr_err = 0;
  logic [4:0] rq2_wptr = '0;
  logic [3:0] raddr;
  logic [4:0] rptr, rlevel;
  logic rempty, raempty, runderflow;
  int checks = 0, errors = 0;
  bit inv_en = 0;
  logic [4:0] rb;

  rptr_empty_lvl #(.ASIZE(4), .AEMPTY_LVL(2)) dut (
    .rclk(clk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr), .rclr_err(rclr_err),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .raempty(raempty),
    .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // empty flag and zero level must always agree once out of reset
  always @(negedge clk) if (inv_en) begin
    checks++;
    if (rempty !== (rlevel == 5'd0)) begin
      errors++;
      $display("FAIL empty_vs_level: rempty=%b rlevel=%0d", rempty, rlevel);
    end
  end

  task automatic test_reset;
    rrst = 1; rinc = 1; rclr_err = 0; rq2_wptr = 5'd3;
    step; step;
    checks++;
    if ({rempty, raempty, rlevel, rptr, raddr, runderflow} !== {1'b1, 1'b1, 5'd0, 5'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: empty=%b aempty=%b level=%0d rptr=%b raddr=%0d uf=%b expected 1 1 0 00000 0 0",
               rempty, raempty, rlevel, rptr, raddr, runderflow);
    end
    rrst = 0; rinc = 0; rq2_wptr = 5'd0;
    step;
    inv_en = 1;
    checks++;
    if (rempty !== 1'b1 || rlevel !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_idle: empty=%b level=%0d expected 1 0", rempty, rlevel);
    end
  endtask

  task automatic test_fill_drain;
    rq2_wptr = 5'b00111;
    step;
    checks++;
    if (rempty !== 1'b0 || raempty !== 1'b0 || rlevel !== 5'd5) begin
      errors++;
      $display("FAIL fill: empty=%b aempty=%b level=%0d expected 0 0 5", rempty, raempty, rlevel);
    end
    rinc = 1;
    for (int k = 1; k <= 5; k++) begin
      step;
      checks++;
      if (rlevel !== 5'(5 - k) || raempty !== (k >= 3) || rempty !== (k == 5) || raddr !== 4'(k)) begin
        errors++;
        $display("FAIL drain_%0d: level=%0d aempty=%b empty=%b raddr=%0d expected %0d %b %b %0d",
                 k, rlevel, raempty, rempty, raddr, 5 - k, k >= 3, k == 5, k);
      end
    end
    rinc = 0;
  endtask

  task automatic test_underflow;
    rinc = 1;
    step;
    rinc = 0;
    checks++;
    if (rptr !== 5'b00111 || runderflow !== 1'b1 || raddr !== 4'd5) begin
      errors++;
      $display("FAIL underflow_set: rptr=%b uf=%b raddr=%0d expected 00111 1 5", rptr, runderflow, raddr);
    end
    step;
    checks++;
    if (runderflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow_hold: uf=%b expected 1", runderflow);
    end
    rclr_err = 1;
    step;
    checks++;
    if (runderflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_clear: uf=%b expected 0", runderflow);
    end
    rinc = 1;
    step;
    checks++;
    if (runderflow !== 1'b1 || rptr !== 5'b00111) begin
      errors++;
      $display("FAIL underflow_set_wins: uf=%b rptr=%b expected 1 00111", runderflow, rptr);
    end
    rinc = 0;
    step;
    rclr_err = 0;
    checks++;
    if (runderflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_reclear: uf=%b expected 0", runderflow);
    end
  endtask

  task automatic test_wrap_full;
    logic [4:0] prev;
    bit saw_ptr_wrap = 0, saw_addr_wrap = 0;
    logic [3:0] prev_addr;
    rb = 5'd5;
    prev = rptr;
    for (int i = 0; i < 40; i++) begin
      rq2_wptr = gray(rb + 5'd1);
      step;
      prev_addr = raddr;
      rinc = 1;
      step;
      rinc = 0;
      rb = rb + 5'd1;
      checks++;
      if (rptr !== gray(rb) || $countones(rptr ^ prev) != 1 || raddr !== rb[3:0] || rempty !== 1'b1) begin
        errors++;
        $display("FAIL wrap_%0d: rptr=%b prev=%b raddr=%0d empty=%b expected rptr=%b raddr=%0d empty=1",
                 i, rptr, prev, raddr, rempty, gray(rb), rb[3:0]);
      end
      if (prev == 5'b10000 && rptr == 5'd0) saw_ptr_wrap = 1;
      if (prev_addr == 4'd15 && raddr == 4'd0) saw_addr_wrap = 1;
      prev = rptr;
    end
    checks++;
    if (!saw_ptr_wrap || !saw_addr_wrap) begin
      errors++;
      $display("FAIL wrap_seen: ptr_wrap=%b addr_wrap=%b expected 1 1", saw_ptr_wrap, saw_addr_wrap);
    end
    rq2_wptr = gray(rb + 5'd16);
    step;
    checks++;
    if (rlevel !== 5'b10000 || rempty !== 1'b0 || raempty !== 1'b0) begin
      errors++;
      $display("FAIL full: level=%b empty=%b aempty=%b expected 10000 0 0", rlevel, rempty, raempty);
    end
    rinc = 1;
    repeat (13) step;
    rinc = 0;
    rb = rb + 5'd13;
    checks++;
    if (rlevel !== 5'd3 || raddr !== rb[3:0]) begin
      errors++;
      $display("FAIL drain_to_3: level=%0d raddr=%0d expected 3 %0d", rlevel, raddr, rb[3:0]);
    end
  endtask

  task automatic test_simultaneous;
    rinc = 1;
    rq2_wptr = gray(rb + 5'd4);
    step;
    rinc = 0;
    rb = rb + 5'd1;
    checks++;
    if (rlevel !== 5'd3 || raempty !== 1'b0 || raddr !== rb[3:0]) begin
      errors++;
      $display("FAIL simultaneous: level=%0d aempty=%b raddr=%0d expected 3 0 %0d", rlevel, raempty, raddr, rb[3:0]);
    end
  endtask

  task automatic test_reset_mid;
    rq2_wptr = gray(rb + 5'd7);
    step;
    checks++;
    if (rlevel !== 5'd7) begin
      errors++;
      $display("FAIL level_7: level=%0d expected 7", rlevel);
    end
    rrst = 1; rinc = 1;
    step;
    rrst = 0; rinc = 0;
    checks++;
    if ({rempty, raempty, rlevel, rptr, raddr, runderflow} !== {1'b1, 1'b1, 5'd0, 5'd0, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: empty=%b aempty=%b level=%0d rptr=%b raddr=%0d uf=%b expected 1 1 0 00000 0 0",
               rempty, raempty, rlevel, rptr, raddr, runderflow);
    end
    rq2_wptr = gray(5'd3);
    step;
    checks++;
    if (rlevel !== 5'd3 || rempty !== 1'b0 || raempty !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_mid: level=%0d empty=%b aempty=%b expected 3 0 0", rlevel, rempty, raempty);
    end
  endtask

  initial begin
    test_reset;
    test_fill_drain;
    test_underflow;
    test_wrap_full;
    test_simultaneous;
    test_reset_mid;
    inv_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
